// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART byte transmitter.
//   tx_state_e     : frame sequencer state encoding
//   PARITY_*       : PARITY_MODE encodings
//   calc_baud_div  : clocks per bit; returns 0 when the result is unusable (< 2)
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // A zero return marks an invalid clock/baud pairing so the caller can stop
  // elaboration with a readable message.
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    int div;
    if (baud <= 0) begin
      return 0;
    end
    div = clk_freq / baud;
    if (div < 2) begin
      return 0;
    end
    return div;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer for the UART transmitter.
//   clk      : system clock
//   reset_p  : synchronous active-high reset
//   clr      : hold the count at 0 (used while the line is idle)
//   bit_end  : high in the last clock of a bit period (count == BAUD_DIV-1)
// The count wraps to 0 on bit_end, so every state entry after a bit end
// starts from 0 without an explicit clear.
module uart_baud_cnt #(
  parameter int BAUD_DIV = 10
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// Asynchronous serial transmitter: one byte per uart_send_en pulse, LSB first,
// optional even/odd parity, 1 or 2 stop bits.
//   clk           : system clock
//   reset_p       : synchronous active-high reset
//   uart_send_en  : one-cycle send request (honoured only when idle)
//   uart_tx_data  : byte captured in the accept cycle
//   uart_tx       : serial line, idle high, registered
//   uart_tx_done  : one-cycle pulse in the first idle cycle after a frame
//   uart_busy     : high while a frame is on the line, registered
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, waiting for uart_send_en
// ST_START  | driving the start bit (0)
// ST_DATA   | driving shift_q[0], bit_idx_q selects 0..7
// ST_PARITY | driving the parity bit captured at accept
// ST_STOP   | driving 1 for STOP_BITS bit periods
module uart_byte_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       uart_send_en,
  input  logic [7:0] uart_tx_data,
  output logic       uart_tx,
  output logic       uart_tx_done,
  output logic       uart_busy
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_byte_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN &&
      PARITY_MODE != PARITY_ODD) begin : g_bad_parity
    $error("uart_byte_tx: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_end;

  uart_baud_cnt #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_cnt (
    .clk    (clk),
    .reset_p(reset_p),
    .clr    (state_q == ST_IDLE),
    .bit_end(bit_end)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (uart_send_en) state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end && bit_idx_q == 3'd7) begin
          state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (bit_end && stop_idx_q == LAST_STOP) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Shift register, parity and bit/stop indices
  always_comb begin
    shift_d    = shift_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    case (state_q)
      ST_IDLE: begin
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        if (uart_send_en) begin
          shift_d = uart_tx_data;
          if (PARITY_MODE == PARITY_ODD) begin
            par_d = ~^uart_tx_data;
          end else if (PARITY_MODE == PARITY_EVEN) begin
            par_d = ^uart_tx_data;
          end else begin
            par_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          stop_idx_d = stop_idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs are registered from the next-state view so the line changes in
  // the same cycle the state does (start edge one clock after accept).
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
  end

  assign uart_tx      = tx_q;
  assign uart_busy    = busy_q;
  assign uart_tx_done = done_q;

endmodule
